// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the inference-bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_OWNED      = 2'd1,
        ARB_TURNAROUND = 2'd2
    } ARB_STATE_T;

    localparam int MASTER_REQ_IDX     = 0;
    localparam int CIM_REQ_IDX_OFFSET = 1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select with master override
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 65,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    input  logic               master_prio_en_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    localparam int DW = IDX_W + 1;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic [DW-1:0]        hit_idx;

    assign req_dbl   = {req_i, req_i};
    assign any_req_o = |req_i;

    // The upper copy catches the wrap: bits below rr_ptr in the lower copy are masked off,
    // so the lowest surviving bit is the first requester at or after rr_ptr, circularly.
    always_comb begin
        masked  = '0;
        hit_idx = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            masked[i] = req_dbl[i] && (i >= int'(rr_ptr_i));
        end
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_idx = DW'(i);
            end
        end
    end

    always_comb begin
        if (master_prio_en_i && req_i[MASTER_REQ_IDX]) begin
            winner_o = IDX_W'(MASTER_REQ_IDX);
        end else if (hit_idx >= DW'(NUM_REQ)) begin
            winner_o = IDX_W'(hit_idx - DW'(NUM_REQ));
        end else begin
            winner_o = hit_idx[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - tri-state inference bus arbiter with lock, turnaround and watchdog
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = 65,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               master_prio_en,
    input  logic               err_clr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               turnaround,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   timeout_idx
);

    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES);

    ARB_STATE_T         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   timeout_idx_q, timeout_idx_d;
    logic               turnaround_q, turnaround_d;
    logic               timeout_err_q, timeout_err_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               owner_holds;
    logic               wd_fire;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i            (req),
        .rr_ptr_i         (rr_ptr_q),
        .master_prio_en_i (master_prio_en),
        .winner_o         (winner),
        .any_req_o        (any_req)
    );

    assign owner_holds = req[gnt_idx_q] & lock[gnt_idx_q];
    assign wd_fire     = (state_q == ARB_OWNED) && owner_holds &&
                         (hold_cnt_q == HOLD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        gnt_d         = '0;
        gnt_idx_d     = gnt_idx_q;
        rr_ptr_d      = rr_ptr_q;
        turnaround_d  = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        timeout_idx_d = timeout_idx_q;
        timeout_err_d = timeout_err_q & ~err_clr;

        case (state_q)
            ARB_IDLE, ARB_TURNAROUND: begin
                if (any_req) begin
                    state_d    = ARB_OWNED;
                    gnt_d      = NUM_REQ'(1) << winner;
                    gnt_idx_d  = winner;
                    hold_cnt_d = '0;
                    rr_ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWNED: begin
                if (owner_holds && !wd_fire) begin
                    gnt_d      = gnt_q;
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else begin
                    // Release or revoke: the dead cycle keeps the old and new drivers apart.
                    state_d      = ARB_TURNAROUND;
                    turnaround_d = 1'b1;
                    hold_cnt_d   = '0;
                    if (wd_fire) begin
                        timeout_err_d = 1'b1;
                        timeout_idx_d = gnt_idx_q;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            rr_ptr_q      <= IDX_W'(CIM_REQ_IDX_OFFSET);
            turnaround_q  <= 1'b0;
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            timeout_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            turnaround_q  <= turnaround_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
            timeout_idx_q <= timeout_idx_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_valid   = |gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign turnaround  = turnaround_q;
    assign timeout_err = timeout_err_q;
    assign timeout_idx = timeout_idx_q;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_vs_tr:  assert property (@(posedge clk) disable iff (!rst_n) !(gnt_valid && turnaround));
    a_gnt_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a behavioural model
module tb_bus_arbiter;

    localparam int N  = 65;
    localparam int IW = $clog2(N);
    localparam int TO = 48;
    localparam int VW = N + 2*IW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic          master_prio_en;
    logic          err_clr;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          turnaround;
    logic          timeout_err;
    logic [IW-1:0] timeout_idx;
    logic [VW-1:0] obs;

    int errors = 0;
    int checks = 0;

    // Model: who owns the bus, for how many cycles, and whether we are in the dead cycle
    int m_owner;
    int m_last;
    int m_tenure;
    bit m_gap;
    int m_rr;
    bit m_err;
    int m_tidx;

    bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .lock           (lock),
        .master_prio_en (master_prio_en),
        .err_clr        (err_clr),
        .gnt            (gnt),
        .gnt_valid      (gnt_valid),
        .gnt_idx        (gnt_idx),
        .turnaround     (turnaround),
        .timeout_err    (timeout_err),
        .timeout_idx    (timeout_idx)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, gnt_valid, gnt_idx, turnaround, timeout_err, timeout_idx};

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, (m_owner >= 0), IW'(m_last), m_gap, m_err, IW'(m_tidx)};
    endfunction

    function automatic int pick();
        if (master_prio_en && req[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_tenure = 0; m_gap = 0;
        m_rr = 1; m_err = 0; m_tidx = 0;
    endtask

    task automatic model_step();
        bit holds;
        bit fire;
        int w;
        fire = 0;
        if (m_owner >= 0) begin
            holds = req[m_owner] && lock[m_owner];
            if (holds && m_tenure < TO) begin
                m_tenure++;
            end else begin
                fire = holds;
                if (fire) m_tidx = m_owner;
                m_owner = -1;
                m_gap = 1;
            end
        end else begin
            m_gap = 0;
            w = pick();
            if (w >= 0) begin
                m_owner = w; m_last = w; m_tenure = 1; m_rr = (w + 1) % N;
            end
        end
        m_err = fire || (m_err && !err_clr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0; lock = '0; master_prio_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; lock = '0; master_prio_en = 1'b0; err_clr = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold obs=%h exp=0", obs); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_single();
        logic [N-1:0] one5;
        one5 = '0; one5[5] = 1'b1;
        apply_reset();
        req[5] = 1'b1;
        tick();
        checks++;
        if (gnt !== one5) begin errors++; $display("FAIL single_gnt got=%h exp=%h", gnt, one5); end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL single_model1 obs=%h exp=%h", obs, exp_vec()); end
        req = '0;
        tick();
        checks++;
        if ({turnaround, gnt_valid} !== 2'b10) begin errors++; $display("FAIL single_tr got=%b exp=10", {turnaround, gnt_valid}); end
        tick();
        checks++;
        if ({turnaround, gnt_valid} !== 2'b00) begin errors++; $display("FAIL single_idle got=%b exp=00", {turnaround, gnt_valid}); end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL single_model3 obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_round_robin();
        int exp_seq[4];
        exp_seq = '{3, 10, 64, 3};
        apply_reset();
        req[3] = 1'b1; req[10] = 1'b1; req[64] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rr_model c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
            checks++;
            if (c % 2 == 0) begin
                if (!gnt_valid || gnt_idx !== IW'(exp_seq[c/2])) begin
                    errors++; $display("FAIL rr_order c=%0d got=%0d exp=%0d", c, gnt_idx, exp_seq[c/2]);
                end
            end else if (turnaround !== 1'b1 || gnt_valid !== 1'b0) begin
                errors++; $display("FAIL rr_gap c=%0d got_tr=%b exp=1", c, turnaround);
            end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_master_prio();
        int exp_idx;
        for (int p = 1; p >= 0; p--) begin
            apply_reset();
            req[19] = 1'b1;
            tick();
            req = '0;
            tick(); tick();
            req[0] = 1'b1; req[20] = 1'b1; master_prio_en = (p == 1);
            tick();
            exp_idx = (p == 1) ? 0 : 20;
            checks++;
            if (!gnt_valid || gnt_idx !== IW'(exp_idx)) begin
                errors++; $display("FAIL prio_p%0d got=%0d exp=%0d", p, gnt_idx, exp_idx);
            end
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL prio_model p=%0d obs=%h exp=%h", p, obs, exp_vec()); end
            req = '0; master_prio_en = 1'b0;
            tick(); tick();
        end
    endtask

    task automatic test_locked_hold();
        int n7;
        n7 = 0;
        apply_reset();
        req[7] = 1'b1; lock[7] = 1'b1; req[8] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (gnt[7]) n7++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL lock_model c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
        end
        req[7] = 1'b0; lock[7] = 1'b0;
        tick();
        checks++;
        if (turnaround !== 1'b1 || gnt !== '0) begin errors++; $display("FAIL lock_tr got=%b exp=1", turnaround); end
        tick();
        checks++;
        if (!gnt_valid || gnt_idx !== IW'(8)) begin errors++; $display("FAIL lock_next got=%0d exp=8", gnt_idx); end
        checks++;
        if (n7 != 40) begin errors++; $display("FAIL lock_len got=%0d exp=40", n7); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL lock_noerr got=%b exp=0", timeout_err); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_watchdog();
        int n2;
        n2 = 0;
        apply_reset();
        req[2] = 1'b1; lock[2] = 1'b1;
        for (int c = 1; c <= TO + 1; c++) begin
            tick();
            if (gnt[2]) n2++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL wd_model c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
        end
        checks++;
        if (n2 != TO) begin errors++; $display("FAIL wd_len got=%0d exp=%0d", n2, TO); end
        checks++;
        if ({turnaround, timeout_err, timeout_idx} !== {1'b1, 1'b1, IW'(2)}) begin
            errors++; $display("FAIL wd_fire got=%b/%b/%0d exp=1/1/2", turnaround, timeout_err, timeout_idx);
        end
        for (int c = TO + 2; c <= 2*TO + 1; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL wd_model2 c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
        end
        err_clr = 1'b1;
        tick();
        checks++;
        if (timeout_err !== 1'b1 || turnaround !== 1'b1) begin
            errors++; $display("FAIL wd_setwins got_err=%b got_tr=%b exp=1/1", timeout_err, turnaround);
        end
        err_clr = 1'b0; req = '0; lock = '0;
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", timeout_err); end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL wd_model3 obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req[9] = 1'b1; lock[9] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (!gnt_valid || gnt_idx !== IW'(9)) begin errors++; $display("FAIL ar_own got=%0d exp=9", gnt_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || gnt_valid !== 1'b0) begin errors++; $display("FAIL ar_drop got=%h exp=0", gnt); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (!gnt_valid || gnt_idx !== IW'(9) || turnaround !== 1'b0) begin
            errors++; $display("FAIL ar_regrant got=%0d/%b exp=9/0", gnt_idx, turnaround);
        end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL ar_model obs=%h exp=%h", obs, exp_vec()); end
        req = '0; lock = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        int pool[6];
        apply_reset();
        pool[0] = 0; pool[1] = 64;
        for (int i = 2; i < 6; i++) pool[i] = $urandom_range(N - 1);
        for (int i = 0; i < 6; i++) req[pool[i]] = 1'($urandom_range(1));
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(39) == 0) req[pool[i]] = ~req[pool[i]];
            end
            lock = '1;
            if ($urandom_range(15) == 0) begin
                for (int i = 0; i < N; i++) lock[i] = 1'($urandom_range(1));
            end
            master_prio_en = ($urandom_range(3) == 0);
            err_clr = ($urandom_range(31) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rand_model c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
        end
        req = '0; lock = '0; master_prio_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; lock = '0; master_prio_en = 1'b0; err_clr = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_master_prio();
        test_locked_hold();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
